// File: rtl/pp_pipeline_accel_axistream2pix.sv
// Unpacks 64-bit words from the ldata FIFO into byte-contiguous 24-bit RGB pixels.
// A 128-bit gearbox absorbs the 64/24 width mismatch; trailing padding bytes are dropped.
module pp_pipeline_accel_axistream2pix #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned PIX_W  = 24,
    parameter int unsigned DIM_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    input  logic [WORD_W-1:0] ldata_dout,
    input  logic              ldata_empty_n,
    output logic              ldata_read,
    output logic [PIX_W-1:0]  img_din,
    input  logic              img_full_n,
    output logic              img_write
);

    localparam int unsigned BUF_W  = 2 * WORD_W;
    localparam int unsigned NB_W   = $clog2(BUF_W);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PROD_W = CNT_W + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIM_W-1:0]   rows_q;
    logic [DIM_W-1:0]   cols_q;
    logic [CNT_W-1:0]   pix_rem_q;
    logic [CNT_W-1:0]   word_rem_q;
    logic [BUF_W-1:0]   gbuf_q;
    logic [NB_W-1:0]    nbits_q;

    logic               emit_c;
    logic               pop_c;
    logic [NB_W-1:0]    nb_after_c;
    logic [NB_W-1:0]    nbits_next_c;
    logic [BUF_W-1:0]   gbuf_next_c;
    logic [CNT_W-1:0]   area_c;
    logic [CNT_W-1:0]   words_c;

    // Frame size in pixels and in 64-bit words (byte count rounded up to whole words)
    always_comb begin
        area_c  = CNT_W'(rows_q) * CNT_W'(cols_q);
        words_c = CNT_W'((PROD_W'(area_c) * PROD_W'(3) + PROD_W'(7)) >> 3);
    end

    // Gearbox: drain one pixel from the bottom, refill a word above the remaining bits
    always_comb begin
        emit_c       = 1'b0;
        pop_c        = 1'b0;
        nb_after_c   = nbits_q;
        nbits_next_c = nbits_q;
        gbuf_next_c  = gbuf_q;
        if (state_q == S_RUN && !ap_rst) begin
            emit_c     = (nbits_q >= NB_W'(PIX_W)) && (pix_rem_q != '0) && img_full_n;
            nb_after_c = emit_c ? (nbits_q - NB_W'(PIX_W)) : nbits_q;
            pop_c      = (word_rem_q != '0) && (nb_after_c < NB_W'(WORD_W)) && ldata_empty_n;
            gbuf_next_c = (emit_c ? (gbuf_q >> PIX_W) : gbuf_q)
                        | (pop_c ? (BUF_W'(ldata_dout) << nb_after_c) : '0);
            nbits_next_c = nb_after_c + (pop_c ? NB_W'(WORD_W) : '0);
        end
    end

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ap_start) state_d = S_INIT;
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (pix_rem_q == '0 && word_rem_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs; FIFO strobes are suppressed while reset is asserted
    always_comb begin
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        ap_idle    = 1'b0;
        ldata_read = 1'b0;
        img_write  = 1'b0;
        img_din    = gbuf_q[PIX_W-1:0];
        ap_done    = (state_q == S_DONE) && !ap_rst;
        ap_ready   = (state_q == S_DONE) && !ap_rst;
        ap_idle    = (state_q == S_IDLE) && !ap_start;
        ldata_read = pop_c;
        img_write  = emit_c;
    end

    // Frame counters, dimension latches and gearbox storage
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rows_q     <= '0;
            cols_q     <= '0;
            pix_rem_q  <= '0;
            word_rem_q <= '0;
            gbuf_q     <= '0;
            nbits_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        rows_q <= rows;
                        cols_q <= cols;
                    end
                end
                S_INIT: begin
                    pix_rem_q  <= area_c;
                    word_rem_q <= words_c;
                    gbuf_q     <= '0;
                    nbits_q    <= '0;
                end
                S_RUN: begin
                    gbuf_q     <= gbuf_next_c;
                    nbits_q    <= nbits_next_c;
                    pix_rem_q  <= pix_rem_q - CNT_W'(emit_c);
                    word_rem_q <= word_rem_q - CNT_W'(pop_c);
                end
                S_DONE: begin
                    gbuf_q  <= '0;
                    nbits_q <= '0;
                end
                default: begin
                    gbuf_q  <= '0;
                    nbits_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_axistream2pix.sv
// Bench for the 64-bit word to 24-bit pixel unpacker: FIFO model on the input,
// byte-stream reference model on the output.
module tb_pp_pipeline_accel_axistream2pix;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [15:0] rows;
    logic [15:0] cols;
    logic [63:0] ldata_dout;
    logic        ldata_empty_n;
    logic        ldata_read;
    logic [23:0] img_din;
    logic        img_full_n;
    logic        img_write;

    pp_pipeline_accel_axistream2pix dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .rows          (rows),
        .cols          (cols),
        .ldata_dout    (ldata_dout),
        .ldata_empty_n (ldata_empty_n),
        .ldata_read    (ldata_read),
        .img_din       (img_din),
        .img_full_n    (img_full_n),
        .img_write     (img_write)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int errors = 0;
    int checks = 0;

    logic [63:0] fifo_q[$];   // contents of the modelled input FIFO
    logic [63:0] frame_q[$];  // words making up the frame under test
    logic [23:0] got_q[$];    // pixels accepted by the output FIFO
    int pops, bad_pop, bad_push, rdy_bad, first_pop, first_push, done_cyc, done_cnt, cyc;
    bit rst_req;
    logic s_read, s_write, s_done, s_ready, s_idle;
    logic [23:0] s_din;

    function automatic logic [7:0] ref_byte(input int i);
        logic [63:0] w;
        w = frame_q[i / 8];
        return w[8 * (i % 8) +: 8];
    endfunction

    function automatic logic [23:0] ref_pix(input int k);
        return {ref_byte(3 * k + 2), ref_byte(3 * k + 1), ref_byte(3 * k)};
    endfunction

    // Index of first pixel differing from the byte-stream model, -1 if all npix match
    function automatic int first_bad(input int npix);
        if (got_q.size() != npix) return (got_q.size() < npix) ? got_q.size() : npix;
        for (int k = 0; k < npix; k++)
            if (got_q[k] !== ref_pix(k)) return k;
        return -1;
    endfunction

    task automatic clear_obs();
        got_q.delete();
        pops = 0; bad_pop = 0; bad_push = 0; rdy_bad = 0;
        first_pop = -1; first_push = -1; done_cyc = -1; done_cnt = 0; cyc = 0;
    endtask

    // One clock: drive inputs after the edge, sample at the falling edge, update models
    task automatic tick(input bit start, input int full_pct, input int gap_pct);
        @(posedge ap_clk);
        #1;
        ap_rst     = rst_req;
        ap_start   = start;
        img_full_n = ($urandom_range(0, 99) >= full_pct);
        if (fifo_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
            ldata_empty_n = 1'b1;
            ldata_dout    = fifo_q[0];
        end else begin
            ldata_empty_n = 1'b0;
            ldata_dout    = {$urandom, $urandom};
        end
        #4;
        s_read = ldata_read; s_write = img_write; s_din = img_din;
        s_done = ap_done; s_ready = ap_ready; s_idle = ap_idle;
        if (ldata_read) begin
            if (ldata_empty_n) void'(fifo_q.pop_front());
            else bad_pop++;
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (img_write) begin
            if (img_full_n) got_q.push_back(img_din);
            else bad_push++;
            if (first_push < 0) first_push = cyc;
        end
        if (ap_ready !== ap_done) rdy_bad++;
        if (ap_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic run_frame(input int r, input int c, input int full_pct, input int gap_pct,
                             input int max_cyc, input bit hold);
        clear_obs();
        rows = 16'(r);
        cols = 16'(c);
        tick(1'b1, full_pct, gap_pct);
        while (done_cyc < 0 && cyc < max_cyc) tick(hold, full_pct, gap_pct);
    endtask

    task automatic load_test1_words();
        fifo_q.delete();
        frame_q.delete();
        frame_q.push_back(64'h0807060504030201);
        frame_q.push_back(64'h100F0E0D0C0B0A09);
        frame_q.push_back(64'h1817161514131211);
        foreach (frame_q[i]) fifo_q.push_back(frame_q[i]);
    endtask

    task automatic test_reset();
        rst_req = 1'b1;
        clear_obs();
        repeat (3) tick(1'b0, 0, 0);
        checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", s_idle); end
        checks++; if ({s_done, s_ready, s_read, s_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {s_done, s_ready, s_read, s_write}); end
        checks++; if (s_din !== 24'h0) begin errors++; $display("FAIL reset_din got=%h exp=000000", s_din); end
        rst_req = 1'b0;
        tick(1'b0, 0, 0);
        checks++; if (s_idle !== 1'b1 || s_done !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got idle=%b done=%b exp idle=1 done=0", s_idle, s_done); end
    endtask

    task automatic test_single_frame();
        logic [23:0] exp1 [8] = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A,
                                  24'h0F0E0D, 24'h121110, 24'h151413, 24'h181716};
        load_test1_words();
        run_frame(1, 8, 0, 0, 100, 1'b0);
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL t1_done timeout after %0d cycles", cyc); end
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL t1_count got=%0d exp=8", got_q.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got_q[k] !== exp1[k]) begin errors++; $display("FAIL t1_pix%0d got=%h exp=%h", k, got_q[k], exp1[k]); end
            end
        end
        checks++; if (pops != 3) begin errors++; $display("FAIL t1_pops got=%0d exp=3", pops); end
        checks++; if (first_pop != 2 || first_push != 3) begin
            errors++; $display("FAIL t1_latency got pop=%0d push=%0d exp pop=2 push=3", first_pop, first_push); end
        tick(1'b0, 0, 0);
        checks++; if (done_cnt != 1 || s_idle !== 1'b1 || rdy_bad != 0) begin
            errors++; $display("FAIL t1_done_pulse got cnt=%0d idle=%b rdy_bad=%0d exp 1/1/0", done_cnt, s_idle, rdy_bad); end
    endtask

    task automatic test_padding();
        logic [23:0] exp2 [3] = '{24'h030201, 24'h060504, 24'h090807};
        fifo_q.delete();
        fifo_q.push_back(64'h0807060504030201);
        fifo_q.push_back(64'hFFFFFFFFFFFFFF09);
        fifo_q.push_back(64'hDEADBEEFCAFEF00D);
        run_frame(1, 3, 0, 0, 100, 1'b0);
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL t2_done timeout after %0d cycles", cyc); end
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL t2_count got=%0d exp=3", got_q.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got_q[k] !== exp2[k]) begin errors++; $display("FAIL t2_pix%0d got=%h exp=%h", k, got_q[k], exp2[k]); end
            end
        end
        checks++; if (pops != 2) begin errors++; $display("FAIL t2_pops got=%0d exp=2", pops); end
        checks++; if (fifo_q.size() != 1 || fifo_q[0] !== 64'hDEADBEEFCAFEF00D) begin
            errors++; $display("FAIL t2_fifo_left got size=%0d exp size=1 head=deadbeefcafef00d", fifo_q.size()); end
        tick(1'b0, 0, 0);
    endtask

    task automatic test_empty_frame();
        int dims [2][2] = '{'{0, 5}, '{3, 0}};
        for (int t = 0; t < 2; t++) begin
            fifo_q.delete();
            fifo_q.push_back(64'h1122334455667788);
            run_frame(dims[t][0], dims[t][1], 0, 0, 20, 1'b0);
            checks++; if (done_cyc < 0 || done_cyc > 3) begin
                errors++; $display("FAIL t3_done_cyc%0d got=%0d exp=0..3", t, done_cyc); end
            checks++; if (pops != 0 || first_push != -1) begin
                errors++; $display("FAIL t3_traffic%0d got pops=%0d push_at=%0d exp 0/-1", t, pops, first_push); end
            tick(1'b0, 0, 0);
        end
    endtask

    task automatic test_random_frame();
        int npix, nwords, b;
        npix   = 4 * 1920;
        nwords = (npix * 3 + 7) / 8;
        fifo_q.delete();
        frame_q.delete();
        for (int i = 0; i < nwords; i++) frame_q.push_back({$urandom, $urandom});
        foreach (frame_q[i]) fifo_q.push_back(frame_q[i]);
        run_frame(4, 1920, 50, 30, 60000, 1'b0);
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL t4_done timeout after %0d cycles", cyc); end
        checks++; if (got_q.size() != npix) begin errors++; $display("FAIL t4_pushes got=%0d exp=%0d", got_q.size(), npix); end
        checks++; if (pops != nwords) begin errors++; $display("FAIL t4_pops got=%0d exp=%0d", pops, nwords); end
        b = first_bad(npix);
        checks++; if (b != -1) begin errors++; $display("FAIL t4_stream first bad index=%0d of %0d pixels", b, npix); end
        checks++; if (bad_pop != 0 || bad_push != 0 || rdy_bad != 0) begin
            errors++; $display("FAIL t4_handshake got bad_pop=%0d bad_push=%0d rdy_bad=%0d exp 0/0/0", bad_pop, bad_push, rdy_bad); end
        tick(1'b0, 0, 0);
    endtask

    task automatic test_mid_reset();
        int b, fsz;
        fifo_q.delete();
        frame_q.delete();
        for (int i = 0; i < 150; i++) frame_q.push_back({$urandom, $urandom});
        foreach (frame_q[i]) fifo_q.push_back(frame_q[i]);
        clear_obs();
        rows = 16'd1;
        cols = 16'd400;
        tick(1'b1, 0, 0);
        while (got_q.size() < 100 && cyc < 1000) tick(1'b0, 0, 0);
        b = first_bad(100);
        checks++; if (b != -1) begin errors++; $display("FAIL t5_prefix first bad index=%0d got %0d pixels", b, got_q.size()); end
        fsz = fifo_q.size();
        rst_req = 1'b1;
        tick(1'b0, 0, 0);
        checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin
            errors++; $display("FAIL t5_rst_strobes got read=%b write=%b exp 0/0", s_read, s_write); end
        rst_req = 1'b0;
        tick(1'b0, 0, 0);
        checks++; if (s_idle !== 1'b1 || s_din !== 24'h0 || s_read !== 1'b0 || s_write !== 1'b0) begin
            errors++; $display("FAIL t5_after_rst got idle=%b din=%h read=%b write=%b exp 1/000000/0/0",
                               s_idle, s_din, s_read, s_write); end
        checks++; if (fifo_q.size() != fsz) begin errors++; $display("FAIL t5_fifo_kept got=%0d exp=%0d", fifo_q.size(), fsz); end
        load_test1_words();
        run_frame(1, 8, 0, 0, 100, 1'b0);
        b = first_bad(8);
        checks++; if (done_cyc < 0 || b != -1 || pops != 3) begin
            errors++; $display("FAIL t5_refresh got done=%0d bad=%0d pops=%0d exp done>=0 bad=-1 pops=3", done_cyc, b, pops); end
        tick(1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a_words[$];
        logic [63:0] b_words[$];
        int b;
        for (int i = 0; i < 2; i++) a_words.push_back({$urandom, $urandom});
        for (int i = 0; i < 3; i++) b_words.push_back({$urandom, $urandom});
        fifo_q.delete();
        foreach (a_words[i]) fifo_q.push_back(a_words[i]);
        foreach (b_words[i]) fifo_q.push_back(b_words[i]);
        frame_q = a_words;
        run_frame(1, 5, 0, 0, 100, 1'b1);
        b = first_bad(5);
        checks++; if (done_cyc < 0 || b != -1 || pops != 2) begin
            errors++; $display("FAIL t6_frame_a got done=%0d bad=%0d pops=%0d exp done>=0 bad=-1 pops=2", done_cyc, b, pops); end
        frame_q = b_words;
        run_frame(2, 3, 0, 0, 100, 1'b1);
        checks++; if (first_pop != 2) begin errors++; $display("FAIL t6_restart first pop got=%0d exp=2", first_pop); end
        b = first_bad(6);
        checks++; if (done_cyc < 0 || b != -1 || pops != 3 || fifo_q.size() != 0) begin
            errors++; $display("FAIL t6_frame_b got done=%0d bad=%0d pops=%0d left=%0d exp bad=-1 pops=3 left=0",
                               done_cyc, b, pops, fifo_q.size()); end
        tick(1'b0, 0, 0);
        tick(1'b0, 0, 0);
        checks++; if (s_idle !== 1'b1) begin errors++; $display("FAIL t6_idle got=%b exp=1", s_idle); end
    endtask

    initial begin
        ap_rst = 1'b1; rst_req = 1'b1; ap_start = 1'b0;
        rows = '0; cols = '0;
        img_full_n = 1'b1; ldata_empty_n = 1'b0; ldata_dout = '0;
        test_reset();
        test_single_frame();
        test_padding();
        test_empty_frame();
        test_random_frame();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
